out_byte_uart: RTL and testbench
================================

// Module: out_byte_uart
//
// PURPOSE
// Consumes the out_byte/out_byte_en character stream produced by the SoC top
// and serialises it as 8N1 UART on a single output pin for board-level console
// output. A byte FIFO absorbs bursts from the CPU, and a transmit FSM drains it
// at a fixed bit rate. The block sits between the system output port and the
// FPGA TX pin, and replaces the simulation-only $write console on hardware.
//
// PARAMETERS
// CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal >= 2
// DEPTH         16   FIFO entries; power of two, >= 2
//
// PORTS
// clk          in   1                  system clock, all logic on rising edge
// reset        in   1                  synchronous, active-high reset
// out_byte     in   8                  character from system, valid with out_byte_en
// out_byte_en  in   1                  1-cycle write strobe, no back-pressure
// uart_tx      out  1                  serial line, idle high
// busy         out  1                  1 when the FSM is not IDLE or the FIFO is non-empty
// fifo_full    out  1                  fifo_level == DEPTH
// fifo_level   out  $clog2(DEPTH)+1    current FIFO occupancy
// overflow     out  1                  sticky: a byte was dropped because the FIFO was full
//
// BEHAVIOUR
// - Reset (sampled at the edge): uart_tx=1, busy=0, fifo_full=0, fifo_level=0,
//   overflow=0, FSM=IDLE, FIFO pointers=0. Reset mid-frame truncates the frame;
//   the line is high after that edge. Queued bytes are discarded.
// - Push: a byte is accepted at the edge where out_byte_en=1 and fifo_full=0
//   (registered value from before the edge).
// - Push with fifo_full=1: the byte is dropped and overflow sets. This holds even
//   if a pop occurs at the same edge.
// - overflow is cleared only by reset.
// - Pop: occurs only in IDLE with fifo_level>0. The head byte loads the shift
//   register at that edge and the FSM moves to START.
// - Push and pop at the same edge: fifo_level is unchanged.
// - FSM states:
//   - IDLE: uart_tx=1.
//   - START: uart_tx=0 for CLKS_PER_BIT cycles.
//   - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
//   - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
// - Bit timing: a down-counter reloads to CLKS_PER_BIT-1 on each state/bit entry.
//   It advances when the count is 0. A 3-bit index counts DATA bits 0..7.
// - Latency: out_byte_en sampled at edge N into an empty FIFO with the FSM in IDLE
//   -> pop at edge N+1 -> uart_tx low from edge N+1.
// - Frame length: 10*CLKS_PER_BIT cycles.
// - Back-to-back frames: STOP -> IDLE -> pop. There is exactly 1 idle-high clk
//   between frames, i.e. a frame period of 10*CLKS_PER_BIT+1.
// - Output timing: uart_tx is driven from a flop (glitch-free). Pointers wrap
//   modulo DEPTH. fifo_level uses an extra MSB so that full and empty are distinct.
// - busy falls at the edge where STOP completes and the FIFO is empty.
//
// TESTING  (bench: CLKS_PER_BIT=4, DEPTH=4)
// 1. Write 0x55 once
//    -> uart_tx = 0,1,0,1,0,1,0,1,0,1, each for 4 clks (40 clks total);
//       busy=0 exactly 41 clks after the write edge.
// 2. Write 0x48 then 0x69 on consecutive clks
//    -> 0x48 frame, then 1 idle clk, then 0x69 frame; a UART-model decoder reads "Hi".
// 3. Write 0x00..0x05 on 6 consecutive clks
//    -> fifo_full at edge 4, byte 0x05 dropped, overflow=1;
//       0x00..0x04 transmitted in order.
// 4. Assert reset during DATA bit 3 of a frame with 2 bytes queued
//    -> next clk: uart_tx=1, fifo_level=0, busy=0, overflow=0; the line stays high.
// 5. Write 0x00 then 0xFF
//    -> 9 low bit-times then stop; then start bit and 9 high bit-times;
//       the decoder reads 0x00, 0xFF.
// 6. Write on the same edge that IDLE pops (fifo_level=1)
//    -> fifo_level stays 1; both bytes are sent in order.

Source files
------------

// File: rtl/out_byte_uart.sv
// Byte FIFO feeding an 8N1 UART transmitter for board-level console output.
// state  | meaning
// IDLE   | line high, pops the FIFO head when one is queued
// START  | start bit (low) for CLKS_PER_BIT clocks
// DATA   | 8 data bits, LSB first, CLKS_PER_BIT clocks each
// STOP   | stop bit (high) for CLKS_PER_BIT clocks, then IDLE
module out_byte_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             out_byte,
  input  logic                   out_byte_en,
  output logic                   uart_tx,
  output logic                   busy,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overflow;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_tick;
  logic [2:0]    w_idx_nxt;

  assign w_full    = (r_level == LEVEL_FULL);
  assign w_push    = out_byte_en && !w_full;
  assign w_pop     = (r_state == S_IDLE) && (r_level != '0);
  assign w_tick    = (r_cnt == '0);
  assign w_idx_nxt = r_idx + 3'd1;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= out_byte;
  end

  // Full is judged on the pre-edge level, so a same-edge pop never rescues a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (out_byte_en && w_full) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW + 1)'(1);
        2'b01:   r_level <= r_level - (AW + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_cnt   <= CNT_RELOAD;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_cnt   <= CNT_RELOAD;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt <= CNT_RELOAD;
            if (r_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_idx <= w_idx_nxt;
              r_tx  <= r_shift[w_idx_nxt];
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (w_tick) r_state <= S_IDLE;
          else        r_cnt   <= r_cnt - CW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_tx    = r_tx;
  assign busy       = (r_state != S_IDLE) || (r_level != '0);
  assign fifo_full  = w_full;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_out_byte_uart.sv
// Directed and random stimulus for out_byte_uart, checked against a frame-schedule model.
module tb_out_byte_uart;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       reset;
  logic [7:0] out_byte;
  logic       out_byte_en;
  logic       uart_tx;
  logic       busy;
  logic       fifo_full;
  logic [2:0] fifo_level;
  logic       overflow;

  out_byte_uart #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .out_byte(out_byte), .out_byte_en(out_byte_en),
    .uart_tx(uart_tx), .busy(busy), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  // Model: each accepted byte owns a frame starting at the edge it is popped.
  int         m_start[$];
  logic [7:0] m_data[$];
  bit         m_ovf;
  logic [7:0] exp_bytes[$];
  logic       line[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  function automatic int occ(input int e);
    int n = 0;
    foreach (m_start[i]) if (m_start[i] > e) n++;
    return n;
  endfunction

  function automatic int active(input int e);
    foreach (m_start[i]) if (e >= m_start[i] && e < m_start[i] + FRAME) return i;
    return -1;
  endfunction

  function automatic logic exp_tx(input int e);
    int a = active(e);
    int k;
    if (a < 0) return 1'b1;
    k = (e - m_start[a]) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_data[a][k-1];
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int e);
    return (active(e) >= 0) || (occ(e) > 0);
  endfunction

  task automatic check_outputs();
    int lvl = occ(edge_no);
    chk("uart_tx",    {31'd0, uart_tx},   {31'd0, exp_tx(edge_no)});
    chk("fifo_level", {29'd0, fifo_level}, lvl);
    chk("fifo_full",  {31'd0, fifo_full}, (lvl == DEPTH) ? 1 : 0);
    chk("busy",       {31'd0, busy},      {31'd0, exp_busy(edge_no)});
    chk("overflow",   {31'd0, overflow},  {31'd0, m_ovf});
  endtask

  task automatic step(input bit en, input logic [7:0] d);
    int s;
    out_byte_en = en;
    out_byte    = d;
    @(posedge clk);
    edge_no++;
    if (en) begin
      if (occ(edge_no - 1) >= DEPTH) m_ovf = 1'b1;
      else begin
        s = edge_no + 1;
        if (m_start.size() > 0 && m_start[$] + FRAME + 1 > s) s = m_start[$] + FRAME + 1;
        m_start.push_back(s);
        m_data.push_back(d);
        exp_bytes.push_back(d);
      end
    end
    #1;
    line.push_back(uart_tx);
    check_outputs();
    out_byte_en = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    out_byte_en = 1'b0;
    @(posedge clk);
    edge_no++;
    m_start.delete();
    m_data.delete();
    m_ovf = 1'b0;
    #1;
    check_outputs();
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && exp_busy(edge_no); i++) step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
  endtask

  task automatic begin_test();
    line.delete();
    exp_bytes.delete();
  endtask

  task automatic decode_check(input string tag);
    logic [7:0] got[$];
    logic [7:0] b;
    int i = 0;
    while (i < line.size()) begin
      if (line[i] == 1'b0 && i + FRAME - 1 < line.size()) begin
        for (int k = 0; k < 8; k++) b[k] = line[i + CPB * (k + 1) + CPB / 2];
        chk({tag, "_stop"}, {31'd0, line[i + 9 * CPB + CPB / 2]}, 1);
        got.push_back(b);
        i += FRAME;
      end else i++;
    end
    chk({tag, "_count"}, got.size(), exp_bytes.size());
    for (int k = 0; k < got.size() && k < exp_bytes.size(); k++)
      chk({tag, "_byte"}, {24'd0, got[k]}, {24'd0, exp_bytes[k]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout edge=%0d", edge_no);
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    reset       = 1'b1;
    out_byte    = 8'h00;
    out_byte_en = 1'b0;
    m_ovf       = 1'b0;
    do_reset();
    do_reset();
    step(1'b0, 8'h00);

    // 1: single byte, busy falls 41 clocks after the write edge
    begin_test();
    step(1'b1, 8'h55);
    w = edge_no;
    for (int i = 0; i < 200 && busy !== 1'b0; i++) step(1'b0, 8'h00);
    chk("t1_busy_fall", edge_no - w, FRAME + 1);
    drain();
    decode_check("t1");

    // 2: "Hi" back to back
    begin_test();
    step(1'b1, 8'h48);
    step(1'b1, 8'h69);
    drain();
    decode_check("t2");

    // 3: overflow on the sixth consecutive write
    begin_test();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(i));
    chk("t3_overflow", {31'd0, overflow}, 1);
    drain();
    decode_check("t3");

    // 4: reset during DATA bit 3 with two bytes queued
    begin_test();
    step(1'b1, 8'hA5);
    step(1'b1, 8'h3C);
    step(1'b1, 8'hC3);
    for (int i = 0; i < 1 + CPB + 3 * CPB - 3; i++) step(1'b0, 8'h00);
    do_reset();
    for (int i = 0; i < 3 * FRAME; i++) step(1'b0, 8'h00);

    // 5: extremes of the data pattern
    begin_test();
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    drain();
    decode_check("t5");

    // 6: write on the edge where IDLE pops
    begin_test();
    step(1'b1, 8'($urandom));
    step(1'b1, 8'($urandom));
    chk("t6_level", {29'd0, fifo_level}, 1);
    drain();
    decode_check("t6");

    // random traffic with gaps and bursts
    for (int r = 0; r < 3; r++) begin
      begin_test();
      for (int i = 0; i < 120; i++)
        step($urandom_range(0, 7) == 0, 8'($urandom));
      drain();
      decode_check("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
